// File: rtl/dortlu_tdm_demux_if.sv
// ---------------------------------------------------------------------------
// dortlu_tdm_demux_if
//   Serial sample stream feeding the TDM demultiplexer.
//   Signals:
//     in_valid  sample/SOF valid this cycle (driven by the source)
//     in_ready  sink can accept a beat     (driven by the demux)
//     in_data   W-bit sample
//     in_sof    start of frame, marks the channel-0 beat
//   Modports:
//     master  the upstream source (serial/mux link side)
//     slave   the demultiplexer
// ---------------------------------------------------------------------------
interface dortlu_tdm_demux_if #(
  parameter int W = 8
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_sof;

  modport master (output in_valid, output in_data, output in_sof, input in_ready);
  modport slave  (input in_valid, input in_data, input in_sof, output in_ready);
endinterface

// File: rtl/dortlu_tdm_demux.sv
// ---------------------------------------------------------------------------
// dortlu_tdm_demux
//   Time-division demultiplexer. A single W-bit lane carries frames of N_CH
//   samples, channel 0 first and flagged with in_sof. The block hunts for a
//   frame start, then steers every accepted beat to its channel's output
//   register and strobes that channel's valid bit for one cycle.
//   Ports:
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     en          block enable; 0 freezes all state and accepts nothing
//     s_in        input stream (in_valid/in_ready/in_data/in_sof)
//     out_data    channel k sample at [k*W +: W], held until overwritten
//     out_valid   one-hot, one-cycle strobe per written channel
//     frame_done  one-cycle pulse when the last channel of a clean frame lands
//     sync_err    one-cycle pulse on a framing violation
//     locked      1 while in the LOCKED state
// ---------------------------------------------------------------------------
module dortlu_tdm_demux #(
  parameter int W    = 8,
  parameter int N_CH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  dortlu_tdm_demux_if.slave     s_in,
  output logic [N_CH*W-1:0]     out_data,
  output logic [N_CH-1:0]       out_valid,
  output logic                  frame_done,
  output logic                  sync_err,
  output logic                  locked
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0]   CH_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CH_ONE  = CW'(1);
  localparam logic [CW-1:0]   CH_LAST = CW'(N_CH - 1);
  localparam logic [N_CH-1:0] VLD_ONE = N_CH'(1);

  typedef enum logic [0:0] {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_ch;
  logic                r_clean;
  logic [N_CH*W-1:0]   r_out_data;
  logic [N_CH-1:0]     r_out_valid;
  logic                r_frame_done;
  logic                r_sync_err;
  logic                r_locked;

  state_t              w_state_nxt;
  logic [CW-1:0]       w_ch_nxt;
  logic                w_clean_nxt;
  logic [N_CH*W-1:0]   w_data_nxt;
  logic [N_CH-1:0]     w_valid_nxt;
  logic                w_fd_nxt;
  logic                w_se_nxt;
  logic                w_wr;
  logic [CW-1:0]       w_wr_ch;
  logic                w_accept;

  assign s_in.in_ready = en;
  assign w_accept      = s_in.in_valid && en;

  // Next-state, channel steering and strobe decode for one accepted beat.
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_clean_nxt = r_clean;
    w_data_nxt  = r_out_data;
    w_valid_nxt = {N_CH{1'b0}};
    w_fd_nxt    = 1'b0;
    w_se_nxt    = 1'b0;
    w_wr        = 1'b0;
    w_wr_ch     = CH_ZERO;
    if (w_accept) begin
      case (r_state)
        S_HUNT: begin
          if (s_in.in_sof) begin
            w_wr        = 1'b1;
            w_wr_ch     = CH_ZERO;
            w_ch_nxt    = CH_ONE;
            w_clean_nxt = 1'b1;
            w_state_nxt = S_LOCKED;
          end else begin
            // Mid-frame garbage while hunting: drop silently.
            w_state_nxt = S_HUNT;
          end
        end
        S_LOCKED: begin
          if (s_in.in_sof) begin
            // Early SOF abandons the partial frame; it never gets frame_done.
            w_se_nxt    = (r_ch != CH_ZERO);
            w_wr        = 1'b1;
            w_wr_ch     = CH_ZERO;
            w_ch_nxt    = CH_ONE;
            w_clean_nxt = 1'b1;
          end else if (r_ch == CH_ZERO) begin
            // Missing SOF at a frame boundary: lose lock, discard the beat.
            w_se_nxt    = 1'b1;
            w_ch_nxt    = CH_ZERO;
            w_clean_nxt = 1'b0;
            w_state_nxt = S_HUNT;
          end else begin
            w_wr     = 1'b1;
            w_wr_ch  = r_ch;
            w_fd_nxt = (r_ch == CH_LAST) ? r_clean : 1'b0;
            w_ch_nxt = r_ch + CH_ONE;
          end
        end
        default: begin
          w_state_nxt = S_HUNT;
          w_ch_nxt    = CH_ZERO;
          w_clean_nxt = 1'b0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
    if (w_wr) begin
      w_data_nxt[w_wr_ch*W +: W] = s_in.in_data;
      w_valid_nxt                = VLD_ONE << w_wr_ch;
    end else begin
      w_valid_nxt = {N_CH{1'b0}};
    end
  end

  // State, channel counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_HUNT;
      r_ch         <= CH_ZERO;
      r_clean      <= 1'b0;
      r_out_data   <= {(N_CH*W){1'b0}};
      r_out_valid  <= {N_CH{1'b0}};
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ch         <= w_ch_nxt;
      r_clean      <= w_clean_nxt;
      r_out_data   <= w_data_nxt;
      r_out_valid  <= w_valid_nxt;
      r_frame_done <= w_fd_nxt;
      r_sync_err   <= w_se_nxt;
      r_locked     <= (w_state_nxt == S_LOCKED);
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;
  assign locked     = r_locked;

endmodule

// File: tb/tb_dortlu_tdm_demux.sv
// ---------------------------------------------------------------------------
// tb_dortlu_tdm_demux
//   Directed vector table for the framing scenarios, a hand-written async
//   reset sequence, and a randomized run scored against a frame-position
//   reference model.
// ---------------------------------------------------------------------------
module tb_dortlu_tdm_demux;

  localparam int W    = 8;
  localparam int N_CH = 4;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [N_CH*W-1:0] out_data;
  logic [N_CH-1:0]   out_valid;
  logic              frame_done;
  logic              sync_err;
  logic              locked;

  dortlu_tdm_demux_if #(.W(W)) s_if ();

  dortlu_tdm_demux #(.W(W), .N_CH(N_CH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .s_in       (s_if),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        v;
    logic        sof;
    logic [7:0]  d;
    logic [3:0]  ev;
    logic        efd;
    logic        ese;
    logic        elk;
    logic [31:0] edata;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic add(input logic e, input logic v, input logic s, input logic [7:0] d,
                     input logic [3:0] ev, input logic fd, input logic se, input logic lk,
                     input logic [31:0] dat);
    vec_t x;
    x.en = e; x.v = v; x.sof = s; x.d = d;
    x.ev = ev; x.efd = fd; x.ese = se; x.elk = lk; x.edata = dat;
    vecs.push_back(x);
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic step(input logic e, input logic v, input logic s, input logic [7:0] d);
    en = e; s_if.in_valid = v; s_if.in_sof = s; s_if.in_data = d;
    #1;
    chk("in_ready", {31'd0, s_if.in_ready}, {31'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] ev, input logic fd,
                          input logic se, input logic lk, input logic [31:0] dat);
    chk({tag, ".out_valid"},  {28'd0, out_valid}, {28'd0, ev});
    chk({tag, ".frame_done"}, {31'd0, frame_done}, {31'd0, fd});
    chk({tag, ".sync_err"},   {31'd0, sync_err}, {31'd0, se});
    chk({tag, ".locked"},     {31'd0, locked}, {31'd0, lk});
    chk({tag, ".out_data"},   out_data, dat);
  endtask

  // Reset asserted/released between clock edges.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    en = 1'b0; s_if.in_valid = 1'b0; s_if.in_sof = 1'b0; s_if.in_data = 8'h00;
    #1;
    chk_outs("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b1;
  endtask

  // Reference model: frame position and per-channel sample memory.
  int         m_pos;
  bit         m_lk;
  bit         m_clean;
  logic [7:0] m_ch [N_CH];

  task automatic rand_run(input int n);
    logic        e, v, s;
    logic [7:0]  d;
    logic [3:0]  ev;
    logic        fd, se;
    logic [31:0] dat;
    int          wr;
    for (int i = 0; i < n; i++) begin
      e = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 3) != 0);
      if (!m_lk)           s = ($urandom_range(0, 1) == 1);
      else if (m_pos == 0) s = ($urandom_range(0, 9) != 0);
      else                 s = ($urandom_range(0, 9) == 0);
      d  = 8'($urandom);
      wr = -1; fd = 1'b0; se = 1'b0;
      if (e && v) begin
        if (!m_lk) begin
          if (s) begin wr = 0; m_pos = 1; m_lk = 1'b1; m_clean = 1'b1; end
        end else if (s) begin
          se = (m_pos != 0); wr = 0; m_pos = 1; m_clean = 1'b1;
        end else if (m_pos == 0) begin
          se = 1'b1; m_lk = 1'b0; m_clean = 1'b0;
        end else begin
          wr = m_pos;
          fd = (m_pos == N_CH - 1) && m_clean;
          m_pos = (m_pos + 1) % N_CH;
        end
      end
      ev = 4'b0000;
      if (wr >= 0) begin
        m_ch[wr] = d;
        ev[wr]   = 1'b1;
      end
      for (int k = 0; k < N_CH; k++) dat[k*8 +: 8] = m_ch[k];
      step(e, v, s, d);
      chk_outs("rand", ev, fd, se, m_lk, dat);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; s_if.in_valid = 1'b0; s_if.in_sof = 1'b0; s_if.in_data = 8'h00;
    #2;
    chk_outs("por", 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    #10;
    rst_n = 1'b1;

    // Hunting: beats without SOF are discarded.
    add(1'b1, 1'b1, 1'b0, 8'h11, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h00000000);
    add(1'b1, 1'b1, 1'b0, 8'h22, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h00000000);
    add(1'b1, 1'b1, 1'b0, 8'h33, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h00000000);
    // Clean frame A1,B2,C3,D4.
    add(1'b1, 1'b1, 1'b1, 8'hA1, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h000000A1);
    add(1'b1, 1'b1, 1'b0, 8'hB2, 4'b0010, 1'b0, 1'b0, 1'b1, 32'h0000B2A1);
    add(1'b1, 1'b1, 1'b0, 8'hC3, 4'b0100, 1'b0, 1'b0, 1'b1, 32'h00C3B2A1);
    add(1'b1, 1'b1, 1'b0, 8'hD4, 4'b1000, 1'b1, 1'b0, 1'b1, 32'hD4C3B2A1);
    // Early SOF after two beats.
    add(1'b1, 1'b1, 1'b1, 8'h10, 4'b0001, 1'b0, 1'b0, 1'b1, 32'hD4C3B210);
    add(1'b1, 1'b1, 1'b0, 8'h20, 4'b0010, 1'b0, 1'b0, 1'b1, 32'hD4C32010);
    add(1'b1, 1'b1, 1'b1, 8'h30, 4'b0001, 1'b0, 1'b1, 1'b1, 32'hD4C32030);
    add(1'b1, 1'b1, 1'b0, 8'h40, 4'b0010, 1'b0, 1'b0, 1'b1, 32'hD4C34030);
    add(1'b1, 1'b1, 1'b0, 8'h50, 4'b0100, 1'b0, 1'b0, 1'b1, 32'hD4504030);
    add(1'b1, 1'b1, 1'b0, 8'h60, 4'b1000, 1'b1, 1'b0, 1'b1, 32'h60504030);
    // Missing SOF at a frame boundary, then relock.
    add(1'b1, 1'b1, 1'b0, 8'h70, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h60504030);
    add(1'b1, 1'b1, 1'b0, 8'h71, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h60504030);
    add(1'b1, 1'b1, 1'b1, 8'h80, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h60504080);
    add(1'b1, 1'b1, 1'b0, 8'h81, 4'b0010, 1'b0, 1'b0, 1'b1, 32'h60508180);
    // Enable dropped with in_valid high (including a stray SOF), then gaps.
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b1, (i == 2) ? 1'b1 : 1'b0, 8'hEE, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h60508180);
    add(1'b1, 1'b0, 1'b0, 8'hEE, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h60508180);
    add(1'b1, 1'b1, 1'b0, 8'h82, 4'b0100, 1'b0, 1'b0, 1'b1, 32'h60828180);
    add(1'b1, 1'b0, 1'b1, 8'hEE, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h60828180);
    add(1'b1, 1'b1, 1'b0, 8'h83, 4'b1000, 1'b1, 1'b0, 1'b1, 32'h83828180);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].v, vecs[i].sof, vecs[i].d);
      chk_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].efd, vecs[i].ese,
               vecs[i].elk, vecs[i].edata);
    end

    // Async reset mid-frame, then SOF is required to relock.
    step(1'b1, 1'b1, 1'b1, 8'h5A);
    step(1'b1, 1'b1, 1'b0, 8'h5B);
    chk_outs("pre_rst", 4'b0010, 1'b0, 1'b0, 1'b1, 32'h83825B5A);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'hC3);
    chk_outs("post_rst_nosof", 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 8'h99);
    chk_outs("post_rst_sof", 4'b0001, 1'b0, 1'b0, 1'b1, 32'h00000099);

    // Randomized run from a fresh reset.
    do_reset();
    m_pos = 0; m_lk = 1'b0; m_clean = 1'b0;
    for (int k = 0; k < N_CH; k++) m_ch[k] = 8'h00;
    rand_run(600);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
